// File: rtl/inst_fetch.sv
// S1 instruction fetch front end: PC, single-outstanding imem reads, small decode queue.
// Define IFETCH_STALL_CNT_EN to add the saturating stall_count output.
module inst_fetch #(
    parameter int            AW       = 16,
    parameter int            IW       = 16,
    parameter logic [AW-1:0] RESET_PC = {AW{1'b0}},
    parameter int            QDEPTH   = 2
) (
    input  logic          clk,
    input  logic          rst,
    output logic          imem_req_valid,
    input  logic          imem_req_ready,
    output logic [AW-1:0] imem_req_addr,
    input  logic          imem_rsp_valid,
    input  logic [IW-1:0] imem_rsp_data,
    input  logic          redirect_valid,
    input  logic [AW-1:0] redirect_pc,
    output logic          inst_valid,
    input  logic          inst_ready,
    output logic [IW-1:0] inst_data,
    output logic [AW-1:0] inst_pc,
`ifdef IFETCH_STALL_CNT_EN
    output logic [2:0]    opcode,
    output logic [15:0]   stall_count
`else
    output logic [2:0]    opcode
`endif
);

    localparam int PW = $clog2(QDEPTH);
    localparam int CW = PW + 1;

    typedef enum logic [1:0] {
        ST_FETCH   = 2'd0,
        ST_WAIT    = 2'd1,
        ST_DISCARD = 2'd2
    } state_t;

    state_t        state_r, state_s;
    logic [AW-1:0] pc_r, pc_s;
    logic [AW-1:0] req_pc_r, req_pc_s;
    logic          outstanding_r, outstanding_s;
    logic [IW-1:0] q_data_r [QDEPTH];
    logic [AW-1:0] q_pc_r   [QDEPTH];
    logic [PW-1:0] rd_ptr_r, wr_ptr_r;
    logic [CW-1:0] count_r;
    logic          credit_s, full_s, req_fire_s, rsp_fire_s;
    logic          pop_s, push_s, flush_s;

    // Queued entries plus the in-flight request may never exceed the queue size.
    assign credit_s       = ((count_r + CW'(outstanding_r)) < CW'(QDEPTH));
    assign full_s         = (count_r == CW'(QDEPTH));
    assign imem_req_valid = !rst && (state_r == ST_FETCH) && credit_s;
    assign imem_req_addr  = pc_r;
    assign req_fire_s     = imem_req_valid && imem_req_ready;
    assign rsp_fire_s     = imem_rsp_valid && outstanding_r;
    assign inst_valid     = (count_r != {CW{1'b0}});
    assign pop_s          = inst_valid && inst_ready;
    assign inst_data      = q_data_r[rd_ptr_r];
    assign inst_pc        = q_pc_r[rd_ptr_r];
    assign opcode         = inst_data[IW-1 -: 3];

    // Fetch FSM next-state: redirect overrides everything
    always_comb begin
        state_s       = state_r;
        pc_s          = pc_r;
        req_pc_s      = req_pc_r;
        outstanding_s = outstanding_r;
        push_s        = 1'b0;
        flush_s       = 1'b0;
        if (redirect_valid) begin
            pc_s    = redirect_pc;
            flush_s = 1'b1;
            if (req_fire_s) begin
                req_pc_s      = pc_r;
                outstanding_s = 1'b1;
                state_s       = ST_DISCARD;
            end else if (outstanding_r && !rsp_fire_s) begin
                state_s = ST_DISCARD;
            end else begin
                outstanding_s = 1'b0;
                state_s       = ST_FETCH;
            end
        end else begin
            case (state_r)
                ST_FETCH: begin
                    if (req_fire_s) begin
                        pc_s          = pc_r + AW'(1);
                        req_pc_s      = pc_r;
                        outstanding_s = 1'b1;
                        state_s       = ST_WAIT;
                    end else begin
                        state_s = ST_FETCH;
                    end
                end
                ST_WAIT: begin
                    if (rsp_fire_s) begin
                        push_s        = 1'b1;
                        outstanding_s = 1'b0;
                        state_s       = ST_FETCH;
                    end else begin
                        state_s = ST_WAIT;
                    end
                end
                ST_DISCARD: begin
                    if (rsp_fire_s) begin
                        outstanding_s = 1'b0;
                        state_s       = ST_FETCH;
                    end else begin
                        state_s = ST_DISCARD;
                    end
                end
                default: begin
                    outstanding_s = 1'b0;
                    state_s       = ST_FETCH;
                end
            endcase
        end
    end

    // Fetch FSM state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r       <= ST_FETCH;
            pc_r          <= RESET_PC;
            req_pc_r      <= {AW{1'b0}};
            outstanding_r <= 1'b0;
        end else begin
            state_r       <= state_s;
            pc_r          <= pc_s;
            req_pc_r      <= req_pc_s;
            outstanding_r <= outstanding_s;
        end
    end

    // Instruction queue storage and pointers; flush wins over push/pop
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr_r <= {PW{1'b0}};
            wr_ptr_r <= {PW{1'b0}};
            count_r  <= {CW{1'b0}};
            for (int i = 0; i < QDEPTH; i++) begin
                q_data_r[i] <= {IW{1'b0}};
                q_pc_r[i]   <= {AW{1'b0}};
            end
        end else if (flush_s) begin
            rd_ptr_r <= {PW{1'b0}};
            wr_ptr_r <= {PW{1'b0}};
            count_r  <= {CW{1'b0}};
        end else begin
            if (push_s) begin
                q_data_r[wr_ptr_r] <= imem_rsp_data;
                q_pc_r[wr_ptr_r]   <= req_pc_r;
                wr_ptr_r           <= wr_ptr_r + PW'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PW'(1);
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CW'(1);
                2'b01:   count_r <= count_r - CW'(1);
                default: count_r <= count_r;
            endcase
        end
    end

`ifdef IFETCH_STALL_CNT_EN
    logic [15:0] stall_cnt_r;

    // Cycles where decode wanted an instruction but none was queued
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_r <= 16'h0000;
        end else if (inst_ready && !inst_valid && (stall_cnt_r != 16'hFFFF)) begin
            stall_cnt_r <= stall_cnt_r + 16'h0001;
        end
    end
    assign stall_count = stall_cnt_r;
`endif

    inst_fetch_chk u_chk (
        .clk  (clk),
        .rst  (rst),
        .push (push_s),
        .full (full_s)
    );

endmodule

// Overflow guard: credit accounting must make a push into a full queue impossible.
module inst_fetch_chk (
    input logic clk,
    input logic rst,
    input logic push,
    input logic full
);
    a_no_overflow: assert property (@(posedge clk) disable iff (rst) !(push && full));
endmodule
